bpu_upd_ctrl: RTL and testbench
===============================

Name: bpu_upd_ctrl

Overview:
Update scheduler for the branch predictor tables (2-bit-counter PHT and BTB). It buffers branch/jump resolutions from the jump unit in a small FIFO and owns the global history register. It issues at most one table write per cycle, yielding to fetch-side lookups with a starvation bound. It also sequences a table-clear sweep after reset or on a predictor flush.

Parameters:
PHT_DEPTH, 64, PHT entries; power of two, >=4; PHT_AW = log2(PHT_DEPTH)
UQ_DEPTH, 4, update FIFO entries; power of two, >=2
STARVE_MAX, 3, max consecutive cycles a pending update may be blocked by lookups

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
flush  in  1  predictor flush request (1-cycle pulse)
res_valid  in  1  resolution valid
res_ready  out  1  resolution accepted when res_valid&&res_ready
res_pc  in  32  resolved instruction PC
res_target  in  32  resolved target
res_taken  in  1  resolved direction
res_is_jal  in  1  unconditional jump (no PHT/GHR update)
res_btb_upd  in  1  BTB write required
fetch_req  in  1  fetch-side table lookup this cycle
fetch_stall  out  1  lookup must be held this cycle (forced write)
ghr  out  PHT_AW  global history, for fetch index hashing
pht_we  out  1  PHT counter update strobe
pht_waddr  out  PHT_AW  PHT index
pht_inc  out  1  1 = saturating increment, 0 = saturating decrement
pht_clr  out  1  write counter to 0 at pht_waddr (sweep)
btb_we  out  1  BTB write strobe
btb_pc  out  32  BTB write PC
btb_target  out  32  BTB write target
init_busy  out  1  clear sweep in progress

Behaviour:
- States: INIT, RUN. Reset (rst==0) -> INIT, sweep counter=0, FIFO empty, ghr=0, starve counter=0; all strobes 0, res_ready=0, init_busy=1.
- INIT: each cycle pht_clr=1, pht_we=0, pht_waddr=sweep counter, and the counter increments. When pht_waddr==PHT_DEPTH-1 is written, go to RUN the next cycle. Sweep takes exactly PHT_DEPTH cycles. init_busy=1 throughout. fetch_req is ignored, so fetch_stall=0.
- flush in any state: next cycle INIT, sweep restarts at 0, FIFO emptied, ghr=0, starve=0. Any resolution handshaked in the flush cycle is discarded.
- res_ready = (state==RUN) && !full. No pass-through when full, even if a pop happens in the same cycle. Push and pop in the same cycle are allowed when not full.
- Entry pushed in cycle N is eligible for issue from cycle N+1 (registered FIFO, head read combinationally).
- Issue condition in RUN: FIFO non-empty and (!fetch_req or starve==STARVE_MAX). Issue pops the head in the same cycle.
- On issue: btb_we=head.btb_upd, with btb_pc/btb_target from the head. If !head.is_jal: pht_we=1, pht_inc=head.taken, pht_waddr=head.pc[2+:PHT_AW]^ghr (current ghr). Then ghr <= {ghr[PHT_AW-2:0], head.taken} next cycle. A JAL entry leaves ghr unchanged.
- fetch_stall=1 only in a cycle where the issue is forced (fetch_req && starve==STARVE_MAX).
- starve: increments each cycle FIFO non-empty && fetch_req && no issue. Clears on any issue or when the FIFO is empty. Saturates at STARVE_MAX.
- Strobes are combinational from state and head. Outside issue/sweep they are 0 and the data outputs hold their last value.
- The PHT saturation arithmetic lives in the table. This block only commands inc/dec/clr.
- FIFO pointers are log2(UQ_DEPTH)+1 bits and wrap modulo 2*UQ_DEPTH; full/empty are derived from the MSB compare.

Test Plan:
- Reset release, PHT_DEPTH=64 -> pht_clr=1 for 64 consecutive cycles with waddr 0..63, then init_busy=0. res_ready=1 at cycle 65.
- RUN, ghr=0, fetch_req=0, push branch pc=0x0000_0010 taken -> next cycle pht_we=1, pht_waddr=4, pht_inc=1. Following cycle ghr=1.
- Push JAL pc=0x100 target=0x200 btb_upd=1 -> btb_we=1, btb_pc=0x100, btb_target=0x200, pht_we=0, ghr unchanged.
- Hold fetch_req=1 with one queued update, STARVE_MAX=3 -> blocked 3 cycles, forced issue on 4th cycle with fetch_stall=1, then starve=0.
- fetch_req=1, push 5 updates back-to-back, UQ_DEPTH=4 -> 4 accepted, res_ready=0 on the 5th. It is accepted only in the cycle after the first pop.
- Flush with 3 queued entries mid-stream -> next cycle init_busy=1, waddr=0, ghr=0, no queued update ever issued, res_ready=0 until the sweep ends.

Source files
------------

// File: rtl/bpu_upd_if.sv
// Branch predictor update bus: resolution input, fetch lookup arbitration,
// PHT/BTB write commands and global history out.
interface bpu_upd_if #(
    parameter int PHT_AW = 6
);
    logic              flush;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_pc;
    logic [31:0]       res_target;
    logic              res_taken;
    logic              res_is_jal;
    logic              res_btb_upd;
    logic              fetch_req;
    logic              fetch_stall;
    logic [PHT_AW-1:0] ghr;
    logic              pht_we;
    logic [PHT_AW-1:0] pht_waddr;
    logic              pht_inc;
    logic              pht_clr;
    logic              btb_we;
    logic [31:0]       btb_pc;
    logic [31:0]       btb_target;
    logic              init_busy;

    // Jump unit / fetch / tables side.
    modport master (
        output flush, res_valid, res_pc, res_target, res_taken, res_is_jal,
               res_btb_upd, fetch_req,
        input  res_ready, fetch_stall, ghr, pht_we, pht_waddr, pht_inc,
               pht_clr, btb_we, btb_pc, btb_target, init_busy
    );

    // Update scheduler side.
    modport slave (
        input  flush, res_valid, res_pc, res_target, res_taken, res_is_jal,
               res_btb_upd, fetch_req,
        output res_ready, fetch_stall, ghr, pht_we, pht_waddr, pht_inc,
               pht_clr, btb_we, btb_pc, btb_target, init_busy
    );
endinterface

// File: rtl/bpu_upd_ctrl.sv
// Branch predictor update scheduler: queues resolutions, owns the global
// history, issues one PHT/BTB write per cycle with a bounded yield to fetch
// lookups, and sweeps the PHT clear after reset or flush.
module bpu_upd_ctrl #(
    parameter int PHT_DEPTH  = 64,
    parameter int UQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input logic    clk,
    input logic    rst,
    bpu_upd_if.slave bus
);
    localparam int PHT_AW = $clog2(PHT_DEPTH);
    localparam int QAW    = $clog2(UQ_DEPTH);
    localparam int SW     = $clog2(STARVE_MAX + 2);

    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [PHT_AW-1:0] SWEEP_LAST = PHT_AW'(PHT_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        is_jal;
        logic        btb_upd;
    } upd_t;

    state_t            state;
    logic [PHT_AW-1:0] sweep;
    logic [QAW:0]      wr_ptr;
    logic [QAW:0]      rd_ptr;
    logic [PHT_AW-1:0] ghr_q;
    logic [SW-1:0]     starve;
    upd_t              mem [UQ_DEPTH];

    logic [PHT_AW-1:0] waddr_q;
    logic              inc_q;
    logic [31:0]       btb_pc_q;
    logic [31:0]       btb_target_q;

    logic              empty;
    logic              full;
    logic              running;
    logic              sweeping;
    logic              issue;
    logic              push;
    upd_t              head;
    upd_t              push_data;
    logic [PHT_AW-1:0] pht_idx;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                       (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
    assign head      = mem[rd_ptr[QAW-1:0]];
    assign running   = rst && (state == ST_RUN);
    assign sweeping  = rst && (state == ST_INIT);
    // A flush cycle issues nothing, so no queued update escapes the flush.
    assign issue     = running && !bus.flush && !empty &&
                       (!bus.fetch_req || (starve == STARVE_LIM));
    assign push      = bus.res_valid && bus.res_ready && !bus.flush;
    assign pht_idx   = head.pc[2 +: PHT_AW] ^ ghr_q;
    assign push_data = '{pc: bus.res_pc, target: bus.res_target,
                         taken: bus.res_taken, is_jal: bus.res_is_jal,
                         btb_upd: bus.res_btb_upd};

    // Table commands and handshake, decoded from state and the FIFO head.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bus.res_ready   = running && !full;
        bus.fetch_stall = issue && bus.fetch_req;
        bus.ghr         = ghr_q;
        bus.init_busy   = !running;
        bus.pht_clr     = sweeping;
        bus.pht_we      = issue && !head.is_jal;
        bus.pht_waddr   = waddr_q;
        bus.pht_inc     = inc_q;
        bus.btb_we      = issue && head.btb_upd;
        bus.btb_pc      = btb_pc_q;
        bus.btb_target  = btb_target_q;
        if (sweeping) begin
            bus.pht_waddr = sweep;
        end else if (bus.pht_we) begin
            bus.pht_waddr = pht_idx;
            bus.pht_inc   = head.taken;
        end
        if (issue) begin
            bus.btb_pc     = head.pc;
            bus.btb_target = head.target;
        end
    end

    // Control state: sweep, FIFO pointers, global history and starvation count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst || bus.flush) begin
            state  <= ST_INIT;
            sweep  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            ghr_q  <= '0;
            starve <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep <= sweep + 1'b1;
                    if (sweep == SWEEP_LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (issue) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (!head.is_jal) begin
                            ghr_q <= {ghr_q[PHT_AW-2:0], head.taken};
                        end
                    end
                    if (issue || empty) begin
                        starve <= '0;
                    end else if (bus.fetch_req && starve != STARVE_LIM) begin
                        starve <= starve + 1'b1;
                    end
                end
            endcase
        end
    end

    // FIFO storage; only written on an accepted resolution.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define what is valid.
        if (push) begin
            mem[wr_ptr[QAW-1:0]] <= push_data;
        end
    end

    // Holds the last driven table address/data while the strobes are idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waddr_q      <= '0;
            inc_q        <= 1'b0;
            btb_pc_q     <= '0;
            btb_target_q <= '0;
        end else begin
            if (bus.pht_clr || bus.pht_we) begin
                waddr_q <= bus.pht_waddr;
            end
            if (bus.pht_we) begin
                inc_q <= bus.pht_inc;
            end
            if (issue) begin
                btb_pc_q     <= head.pc;
                btb_target_q <= head.target;
            end
        end
    end
endmodule

// File: tb/tb_bpu_upd_ctrl.sv
// Self-checking bench for bpu_upd_ctrl: directed scenarios followed by random
// traffic, all compared against a queue-based model of the update scheduler.
module tb_bpu_upd_ctrl;
    localparam int PHT_DEPTH  = 64;
    localparam int UQ_DEPTH   = 4;
    localparam int STARVE_MAX = 3;
    localparam int PHT_AW     = 6;

    logic clk;
    logic rst;

    bpu_upd_if #(.PHT_AW(PHT_AW)) bus ();

    bpu_upd_ctrl #(
        .PHT_DEPTH (PHT_DEPTH),
        .UQ_DEPTH  (UQ_DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus counters derived from the rules.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          tk;
        bit          jal;
        bit          bu;
    } ent_t;

    ent_t q[$];
    bit   m_init;
    int   m_sweep;
    int   m_ghr;
    int   m_starve;

    // One clock cycle: drive inputs, compare settled outputs, advance model.
    task automatic step(input bit f, input bit v, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit tk, input bit jal,
                        input bit bu, input bit fr);
        bit   exp_rdy;
        bit   can_issue;
        bit   exp_we;
        bit   exp_bwe;
        int   idx;
        ent_t h;
        ent_t n;
        bus.flush       = f;
        bus.res_valid   = v;
        bus.res_pc      = pc;
        bus.res_target  = tgt;
        bus.res_taken   = tk;
        bus.res_is_jal  = jal;
        bus.res_btb_upd = bu;
        bus.fetch_req   = fr;
        #1;
        exp_rdy   = !m_init && (q.size() < UQ_DEPTH);
        can_issue = !m_init && !f && (q.size() > 0) &&
                    (!fr || m_starve == STARVE_MAX);
        if (q.size() > 0) h = q[0];
        exp_we  = can_issue && !h.jal;
        exp_bwe = can_issue && h.bu;
        idx     = ((h.pc >> 2) % PHT_DEPTH) ^ m_ghr;

        check("res_ready", 32'(bus.res_ready), 32'(exp_rdy));
        check("init_busy", 32'(bus.init_busy), 32'(m_init));
        check("pht_clr", 32'(bus.pht_clr), 32'(m_init));
        check("fetch_stall", 32'(bus.fetch_stall), 32'(can_issue && fr));
        check("ghr", 32'(bus.ghr), 32'(m_ghr));
        check("pht_we", 32'(bus.pht_we), 32'(exp_we));
        check("btb_we", 32'(bus.btb_we), 32'(exp_bwe));
        if (m_init) check("sweep_addr", 32'(bus.pht_waddr), 32'(m_sweep));
        if (exp_we) begin
            check("pht_waddr", 32'(bus.pht_waddr), 32'(idx));
            check("pht_inc", 32'(bus.pht_inc), 32'(h.tk));
        end
        if (exp_bwe) begin
            check("btb_pc", bus.btb_pc, h.pc);
            check("btb_target", bus.btb_target, h.tgt);
        end

        if (f) begin
            m_init = 1; m_sweep = 0; m_ghr = 0; m_starve = 0;
            q.delete();
        end else if (m_init) begin
            if (m_sweep == PHT_DEPTH - 1) m_init = 0;
            m_sweep++;
        end else begin
            if (can_issue || q.size() == 0) m_starve = 0;
            else if (fr && m_starve < STARVE_MAX) m_starve++;
            if (can_issue) begin
                void'(q.pop_front());
                if (!h.jal) m_ghr = ((m_ghr << 1) | int'(h.tk)) % PHT_DEPTH;
            end
            if (v && exp_rdy) begin
                n.pc = pc; n.tgt = tgt; n.tk = tk; n.jal = jal; n.bu = bu;
                q.push_back(n);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit fr);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0, fr);
    endtask

    initial begin
        rst = 1'b0;
        bus.flush = 0; bus.res_valid = 0; bus.res_pc = '0; bus.res_target = '0;
        bus.res_taken = 0; bus.res_is_jal = 0; bus.res_btb_upd = 0; bus.fetch_req = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.init_busy), 32'd1);
        check("rst_ready", 32'(bus.res_ready), 32'd0);
        check("rst_clr", 32'(bus.pht_clr), 32'd0);
        check("rst_we", 32'(bus.pht_we | bus.btb_we), 32'd0);
        check("rst_ghr", 32'(bus.ghr), 32'd0);
        rst = 1'b1;
        m_init = 1; m_sweep = 0; m_ghr = 0; m_starve = 0;

        // Sweep of 64 clears, then ready.
        idle(PHT_DEPTH + 1, 1);
        check("run_after_sweep", 32'(m_init), 32'd0);

        // Taken branch at pc 0x10 -> index 4, then ghr=1.
        step(0, 1, 32'h10, 32'h40, 1, 0, 0, 0);
        idle(2, 0);
        // JAL with BTB write: no PHT write, ghr unchanged.
        step(0, 1, 32'h100, 32'h200, 1, 1, 1, 0);
        idle(2, 0);
        // Single update blocked by continuous lookups, forced on 4th cycle.
        step(0, 1, 32'h24, 32'h80, 0, 0, 1, 1);
        idle(6, 1);
        // Back-to-back pushes under lookup pressure fill the queue.
        for (int i = 0; i < 9; i++)
            step(0, 1, 32'(i * 4 + 32'h300), 32'(i), i[0], 0, 1, 1);
        idle(12, 1);
        // Flush with three queued entries.
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'(i * 8 + 32'h500), 32'h0, 1, 0, 1, 1);
        step(1, 0, '0, '0, 0, 0, 0, 1);
        idle(PHT_DEPTH + 4, 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 1) == 1),
                 $urandom, $urandom,
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
